// File: rtl/pixel_scheduler.sv
// pixel_scheduler: walks a frame in raster order, hands pixel coordinates to a pool of
// iterator slots and serialises their results. Define FRAME_CYCLE_COUNT_EN to add frame_cycles.
//
// state | meaning
// IDLE  | waiting for start; all slots FREE
// RUN   | dispatching pixels to FREE slots, draining DONE slots to the write port
// DRAIN | last pixel dispatched; waiting for every slot to be written back
module pixel_scheduler #(
   parameter int NUM_ITER = 4,
   parameter int H_RES    = 640,
   parameter int V_RES    = 480
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [26:0]            cr_min,
   input  logic [26:0]            ci_max,
   input  logic [26:0]            step,
   input  logic [31:0]            max_iterations,
   output logic [NUM_ITER*32-1:0] iter_max_iterations,
   output logic [NUM_ITER-1:0]    iter_rst,
   output logic [NUM_ITER*27-1:0] iter_cr,
   output logic [NUM_ITER*27-1:0] iter_ci,
   input  logic [NUM_ITER-1:0]    iter_done,
   input  logic [NUM_ITER*32-1:0] iter_count,
   output logic                   wr_valid,
   input  logic                   wr_ready,
   output logic [18:0]            wr_addr,
   output logic [31:0]            wr_data,
   output logic                   busy,
   output logic                   frame_done
`ifdef FRAME_CYCLE_COUNT_EN
   ,
   output logic [31:0]            frame_cycles
`endif
);

   localparam int SW = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
   localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
   typedef enum logic [1:0] {SL_FREE, SL_BUSY, SL_DONE} slot_t;

   state_t r_state, w_state_nxt;
   slot_t  r_slot [NUM_ITER];
   logic [18:0] r_slot_addr [NUM_ITER];
   logic [NUM_ITER-1:0]    r_iter_rst;
   logic [NUM_ITER-1:0]    r_fresh;
   logic [NUM_ITER*27-1:0] r_iter_cr, r_iter_ci;

   logic [26:0]   r_cr, r_ci, r_cr_min, r_step;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [18:0]   r_pix;

   logic          r_wr_valid;
   logic [18:0]   r_wr_addr;
   logic [31:0]   r_wr_data;
   logic [SW-1:0] r_wr_slot;
   logic [SW-1:0] r_rr_ptr;

   logic          w_free_any, w_disp, w_last, w_all_free;
   logic [SW-1:0] w_disp_slot;
   logic          w_grant_any, w_grant, w_accept, w_start_ok;
   logic [SW-1:0] w_grant_slot;

   // lowest-index FREE slot wins dispatch
   always_comb begin
      w_free_any  = 1'b0;
      w_disp_slot = '0;
      w_all_free  = 1'b1;
      for (int i = NUM_ITER - 1; i >= 0; i--) begin
         if (r_slot[i] == SL_FREE) begin
            w_free_any  = 1'b1;
            w_disp_slot = SW'(i);
         end else begin
            w_all_free = 1'b0;
         end
      end
   end

   // round-robin search starting just after the last granted slot
   always_comb begin
      w_grant_any  = 1'b0;
      w_grant_slot = '0;
      for (int k = NUM_ITER; k >= 1; k--) begin
         if (r_slot[(int'(r_rr_ptr) + k) % NUM_ITER] == SL_DONE) begin
            w_grant_any  = 1'b1;
            w_grant_slot = SW'((int'(r_rr_ptr) + k) % NUM_ITER);
         end
      end
   end

   assign w_start_ok = (r_state == S_IDLE) && start;
   assign w_disp     = (r_state == S_RUN) && w_free_any;
   assign w_last     = (r_x == XW'(H_RES - 1)) && (r_y == YW'(V_RES - 1));
   assign w_grant    = !r_wr_valid && w_grant_any;
   assign w_accept   = r_wr_valid && wr_ready;

   always_comb begin
      w_state_nxt = r_state;
      frame_done  = 1'b0;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_disp && w_last) w_state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (w_all_free && !r_wr_valid) begin
               w_state_nxt = S_IDLE;
               frame_done  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_iter_rst <= '1;
         r_fresh    <= '0;
         r_iter_cr  <= '0;
         r_iter_ci  <= '0;
         for (int i = 0; i < NUM_ITER; i++) begin
            r_slot[i]      <= SL_FREE;
            r_slot_addr[i] <= '0;
         end
         r_cr       <= '0;
         r_ci       <= '0;
         r_cr_min   <= '0;
         r_step     <= '0;
         r_x        <= '0;
         r_y        <= '0;
         r_pix      <= '0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_wr_slot  <= '0;
         r_rr_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (w_start_ok) begin
            r_cr     <= cr_min;
            r_ci     <= ci_max;
            r_cr_min <= cr_min;
            r_step   <= step;
            r_x      <= '0;
            r_y      <= '0;
            r_pix    <= '0;
         end else if (w_disp) begin
            r_pix <= r_pix + 1'b1;
            if (r_x == XW'(H_RES - 1)) begin
               r_x  <= '0;
               r_cr <= r_cr_min;
               r_y  <= r_y + 1'b1;
               r_ci <= r_ci - r_step;
            end else begin
               r_x  <= r_x + 1'b1;
               r_cr <= r_cr + r_step;
            end
         end

         for (int i = 0; i < NUM_ITER; i++) begin
            case (r_slot[i])
               SL_FREE: begin
                  if (w_disp && (w_disp_slot == SW'(i))) begin
                     r_slot[i]            <= SL_BUSY;
                     r_iter_rst[i]        <= 1'b0;
                     r_fresh[i]           <= 1'b1;
                     r_slot_addr[i]       <= r_pix;
                     r_iter_cr[i*27 +: 27] <= r_cr;
                     r_iter_ci[i*27 +: 27] <= r_ci;
                  end
               end
               SL_BUSY: begin
                  // the iterator's done may still be stale in its first cycle out of reset
                  r_fresh[i] <= 1'b0;
                  if (iter_done[i] && !r_fresh[i]) r_slot[i] <= SL_DONE;
               end
               SL_DONE: begin
                  if (w_accept && (r_wr_slot == SW'(i))) begin
                     r_slot[i]     <= SL_FREE;
                     r_iter_rst[i] <= 1'b1;
                  end
               end
               default: r_slot[i] <= SL_FREE;
            endcase
         end

         if (w_grant) begin
            r_wr_valid <= 1'b1;
            r_wr_slot  <= w_grant_slot;
            r_rr_ptr   <= w_grant_slot;
            r_wr_addr  <= r_slot_addr[w_grant_slot];
            r_wr_data  <= iter_count[int'(w_grant_slot)*32 +: 32];
         end else if (w_accept) begin
            r_wr_valid <= 1'b0;
         end
      end
   end

`ifdef FRAME_CYCLE_COUNT_EN
   logic [31:0] r_frame_cycles;

   always_ff @(posedge clk) begin
      if (rst)                   r_frame_cycles <= '0;
      else if (w_start_ok)       r_frame_cycles <= '0;
      else if (r_state != S_IDLE) r_frame_cycles <= r_frame_cycles + 1'b1;
   end

   assign frame_cycles = r_frame_cycles;
`endif

   assign iter_max_iterations = {NUM_ITER{max_iterations}};
   assign iter_rst  = r_iter_rst;
   assign iter_cr   = r_iter_cr;
   assign iter_ci   = r_iter_ci;
   assign wr_valid  = r_wr_valid;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler on a 4x2 frame with two model iterators.
module tb_pixel_scheduler;

   localparam logic [26:0] CRMIN = 27'h7000000;
   localparam logic [26:0] CIMAX = 27'h0800000;
   localparam logic [26:0] STEP  = 27'h0400000;
   localparam logic [31:0] MAXIT = 32'h0000_00FF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start, wr_ready;
   logic [26:0] cr_min, ci_max, step;
   logic [31:0] max_iterations;
   logic [63:0] iter_max_iterations;
   logic [1:0]  iter_rst, iter_done;
   logic [53:0] iter_cr, iter_ci;
   logic [63:0] iter_count;
   logic        wr_valid, busy, frame_done;
   logic [18:0] wr_addr;
   logic [31:0] wr_data;
`ifdef FRAME_CYCLE_COUNT_EN
   logic [31:0] frame_cycles;
`endif

   pixel_scheduler #(.NUM_ITER(2), .H_RES(4), .V_RES(2)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .cr_min              (cr_min),
      .ci_max              (ci_max),
      .step                (step),
      .max_iterations      (max_iterations),
      .iter_max_iterations (iter_max_iterations),
      .iter_rst            (iter_rst),
      .iter_cr             (iter_cr),
      .iter_ci             (iter_ci),
      .iter_done           (iter_done),
      .iter_count          (iter_count),
      .wr_valid            (wr_valid),
      .wr_ready            (wr_ready),
      .wr_addr             (wr_addr),
      .wr_data             (wr_data),
      .busy                (busy),
      .frame_done          (frame_done)
`ifdef FRAME_CYCLE_COUNT_EN
      ,
      .frame_cycles        (frame_cycles)
`endif
   );

   int lat [2]   = '{3, 2};
   int m_cnt [2] = '{0, 0};

   function automatic logic [31:0] pix_val(input logic [26:0] cr, input logic [26:0] ci);
      return {ci[26:11], cr[26:11]} ^ MAXIT;
   endfunction

   function automatic logic [26:0] exp_cr(input int a);
      logic [26:0] v;
      v = CRMIN + 27'(a % 4) * STEP;
      return v;
   endfunction

   function automatic logic [26:0] exp_ci(input int a);
      logic [26:0] v;
      v = CIMAX - 27'(a / 4) * STEP;
      return v;
   endfunction

   // model iterator: done lat[i] cycles after its reset drops, result depends on its coordinate
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (iter_rst[i])          m_cnt[i] <= 0;
         else if (m_cnt[i] < lat[i]) m_cnt[i] <= m_cnt[i] + 1;
      end
   end

   always_comb begin
      iter_done  = '0;
      iter_count = '0;
      for (int i = 0; i < 2; i++) begin
         iter_done[i]           = !iter_rst[i] && (m_cnt[i] == lat[i]);
         iter_count[i*32 +: 32] = pix_val(iter_cr[i*27 +: 27], iter_ci[i*27 +: 27]);
      end
   end

   int n_total = 0, n_bad = 0;
   int n_wr, n_fd, n_busy, disp_n;
   logic [7:0]  seen;
   logic [1:0]  prev_rst;
   logic        chk_order;
   logic [18:0] a0;
   logic [31:0] d0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // called just after a falling edge; handshake values here are what the next rising edge sees
   task automatic tick();
      if (!rst && wr_valid && wr_ready) begin
         chk("wr_addr_range", 64'(wr_addr < 19'd8), 64'd1);
         if (wr_addr < 19'd8) begin
            chk("wr_addr_unique", 64'(seen[wr_addr[2:0]]), 64'd0);
            seen[wr_addr[2:0]] = 1'b1;
            chk("wr_data", 64'(wr_data), 64'(pix_val(exp_cr(int'(wr_addr)), exp_ci(int'(wr_addr)))));
         end
         if (chk_order && n_wr < 2) chk("wr_order", 64'(wr_addr), (n_wr == 0) ? 64'd1 : 64'd0);
         n_wr++;
      end
      @(posedge clk);
      @(negedge clk);
      if (busy) n_busy++;
      if (frame_done) n_fd++;
      for (int i = 0; i < 2; i++) begin
         if (prev_rst[i] && !iter_rst[i]) begin
            chk("disp_cr", 64'(iter_cr[i*27 +: 27]), 64'(exp_cr(disp_n)));
            chk("disp_ci", 64'(iter_ci[i*27 +: 27]), 64'(exp_ci(disp_n)));
            if (disp_n == 5) begin
               chk("addr5_cr", 64'(iter_cr[i*27 +: 27]), 64'h7400000);
               chk("addr5_ci", 64'(iter_ci[i*27 +: 27]), 64'h0400000);
            end
            disp_n++;
         end
      end
      prev_rst = iter_rst;
   endtask

   task automatic start_frame(input logic [26:0] crm);
      cr_min = crm;
      ci_max = CIMAX;
      step   = STEP;
      seen   = '0;
      n_wr   = 0;
      n_fd   = 0;
      n_busy = 0;
      disp_n = 0;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   task automatic wait_frame(input int budget);
      for (int k = 0; k < budget && n_fd == 0; k++) tick();
      chk("frame_done_seen", 64'(n_fd != 0), 64'd1);
   endtask

   task automatic post_frame();
      repeat (3) tick();
      chk("n_writes", 64'(n_wr), 64'd8);
      chk("all_addr", 64'(seen), 64'hFF);
      chk("frame_done_once", 64'(n_fd), 64'd1);
      chk("idle_after", 64'(busy), 64'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; wr_ready = 1'b1;
      cr_min = '0; ci_max = '0; step = '0; max_iterations = MAXIT;
      prev_rst = 2'b11; chk_order = 1'b0;
      n_wr = 0; n_fd = 0; n_busy = 0; disp_n = 0; seen = '0;
      a0 = '0; d0 = '0;
      @(negedge clk);
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_iter_rst", 64'(iter_rst), 64'h3);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_wr_valid", 64'(wr_valid), 64'd0);
      chk("rst_wr_addr", 64'(wr_addr), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_iter_cr", 64'(iter_cr), 64'd0);
      chk("rst_iter_ci", 64'(iter_ci), 64'd0);
      chk("maxit_pass", iter_max_iterations, {MAXIT, MAXIT});

      // both slots finish together; slot 1 must be written before slot 0
      lat = '{3, 2};
      chk_order = 1'b1;
      start_frame(CRMIN);
      wait_frame(200);
      chk_order = 1'b0;
      post_frame();

      // write port back-pressure
      lat = '{2, 2};
      wr_ready = 1'b0;
      start_frame(CRMIN);
      for (int k = 0; k < 50 && !wr_valid; k++) tick();
      chk("bp_valid_rose", 64'(wr_valid), 64'd1);
      a0 = wr_addr;
      d0 = wr_data;
      chk("bp_first_data", 64'(d0), 64'(pix_val(exp_cr(int'(a0)), exp_ci(int'(a0)))));
      repeat (10) begin
         tick();
         chk("bp_valid_hold", 64'(wr_valid), 64'd1);
         chk("bp_addr_hold", 64'(wr_addr), 64'(a0));
         chk("bp_data_hold", 64'(wr_data), 64'(d0));
         chk("bp_no_free", 64'(iter_rst), 64'd0);
      end
      wr_ready = 1'b1;
      wait_frame(200);
      post_frame();

      // stray start while running
      lat = '{1, 3};
      start_frame(CRMIN);
      repeat (3) tick();
      chk("restart_in_run", 64'(busy), 64'd1);
      cr_min = 27'h0000000;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      wait_frame(200);
      post_frame();

      // reset in the middle of a frame
      lat = '{2, 2};
      start_frame(CRMIN);
      repeat (4) tick();
      chk("pre_rst_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_iter_rst", 64'(iter_rst), 64'h3);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_wr_valid", 64'(wr_valid), 64'd0);
      chk("midrst_frame_done", 64'(frame_done), 64'd0);
      n_wr = 0;
      n_fd = 0;
      repeat (20) tick();
      chk("midrst_no_writes", 64'(n_wr), 64'd0);
      chk("midrst_no_done", 64'(n_fd), 64'd0);
      chk("midrst_idle", 64'(busy), 64'd0);

`ifdef FRAME_CYCLE_COUNT_EN
      lat = '{3, 3};
      start_frame(CRMIN);
      wait_frame(200);
      post_frame();
      chk("frame_cycles", 64'(frame_cycles), 64'(n_busy));
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/pixel_scheduler.md
PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

Interface
REQ-001 Parameter NUM_ITER, default 4: number of iterator instances scheduled.
REQ-002 Parameter H_RES, default 640: pixels per row.
REQ-003 Parameter V_RES, default 480: rows per frame.
REQ-004 clk  in  1  single clock; all logic SHALL be on posedge clk.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a frame; ignored unless state is IDLE.
REQ-007 cr_min, ci_max  in  27 each  signed 4.23; top-left pixel coordinate; sampled on an accepted start.
REQ-008 step  in  27  unsigned 4.23 pixel pitch; sampled on an accepted start.
REQ-009 max_iterations  in  32  passed through unchanged to all iterators.
REQ-010 iter_rst  out  NUM_ITER  per-slot iterator reset; the iterator computes while its bit is low.
REQ-011 iter_cr, iter_ci  out  NUM_ITER*27 each  per-slot coordinate; stable while the slot is BUSY.
REQ-012 iter_done  in  NUM_ITER  per-slot done from the iterators.
REQ-013 iter_count  in  NUM_ITER*32  per-slot iteration results.
REQ-014 wr_valid/wr_ready  out/in  1/1  result write handshake.
REQ-015 wr_addr  out  19  pixel address, y*H_RES+x.
REQ-016 wr_data  out  32  iteration count of that pixel.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 frame_done  out  1  one-cycle pulse when a frame completes.

Function
REQ-019 Top FSM SHALL use states IDLE, RUN, DRAIN: accepted start moves IDLE->RUN; last pixel dispatched moves RUN->DRAIN; all slots FREE with no write pending moves DRAIN->IDLE, pulsing frame_done in that cycle.
REQ-020 Each slot SHALL be FREE, BUSY or DONE; the slot address SHALL be latched at dispatch.
REQ-021 Dispatch, in RUN: at most one pixel per cycle, to the lowest-index FREE slot; that slot's iter_rst is held high for exactly the dispatch cycle, then driven low; the slot becomes BUSY.
REQ-022 BUSY->DONE when iter_done is high; iter_done SHALL be ignored during the first cycle after iter_rst falls.
REQ-023 Pixel walk: x increments with cr += step; at x=H_RES-1, x wraps to 0, cr reloads cr_min, y increments and ci -= step. Arithmetic SHALL be 27-bit two's complement, wrapping on overflow with no saturation.
REQ-024 Write arbiter: round-robin among DONE slots, starting from the slot after the last granted slot.
REQ-025 Once wr_valid rises, wr_addr and wr_data SHALL hold until wr_ready is sampled high.
REQ-026 The granted slot SHALL become FREE in the accept cycle, with its iter_rst driven high; it SHALL be dispatchable no earlier than the next cycle.
REQ-027 Simultaneous accept and dispatch on different slots SHALL both proceed in the same cycle.
REQ-028 FREE slots SHALL hold iter_rst high.

Reset
REQ-029 rst SHALL force: state IDLE, all slots FREE, iter_rst all ones, iter_cr/iter_ci 0, wr_valid 0, wr_addr 0, wr_data 0, busy 0, frame_done 0, x/y 0, round-robin pointer 0.
REQ-030 rst asserted mid-frame SHALL abandon the frame with no further writes and no frame_done pulse.

Configuration
REQ-031 With FRAME_CYCLE_COUNT_EN defined: add output frame_cycles (32 bits), cleared on an accepted start, incremented each RUN/DRAIN cycle, held in IDLE, reset to 0; without the macro the port and counter SHALL NOT exist.

Verification (H_RES=4, V_RES=2, NUM_ITER=2, model iterator)
REQ-032 Reset during RUN -> next cycle iter_rst=2'b11, busy=0, wr_valid=0; no frame_done.
REQ-033 start with cr_min=-2.0 (27'h7000000), ci_max=1.0 (27'h0800000), step=0.5 (27'h0400000) -> 8 writes covering addresses 0..7 exactly once; address 5 carries cr=-1.5, ci=0.5 at dispatch; frame_done pulses once.
REQ-034 wr_ready held low 10 cycles -> wr_addr/wr_data stable; no slot freed; no new dispatch once both slots are BUSY or DONE.
REQ-035 Both slots DONE in the same cycle, last grant slot 0 -> slot 1 is written first, then slot 0.
REQ-036 start pulsed during RUN -> ignored; the frame still produces exactly 8 writes.
REQ-037 With FRAME_CYCLE_COUNT_EN defined, a frame with wr_ready tied high and a fixed 3-cycle iterator -> frame_cycles equals the bench-counted busy cycles.
